// File: rtl/rob_multiway_if.sv
// Dispatch / completion / lookup / retire bundle for rob_multiway.
// slave is the ROB side, master is the pipeline driving it.
interface rob_multiway_if #(
  parameter int ROB_DEPTH = 8,
  parameter int DP_WIDTH  = 2,
  parameter int CDB_WIDTH = 2,
  parameter int RT_WIDTH  = 2,
  parameter int LK_PORTS  = 4,
  parameter int XLEN      = 32
);
  localparam int TAG_W = $clog2(ROB_DEPTH);

  logic [DP_WIDTH-1:0]         dp_valid;
  logic [DP_WIDTH-1:0]         dp_has_dest;
  logic [5*DP_WIDTH-1:0]       dp_dest;
  logic [DP_WIDTH-1:0]         dp_is_branch;
  logic                        dp_accept;
  logic [TAG_W*DP_WIDTH-1:0]   dp_tag;
  logic [TAG_W:0]              free_slots;

  logic [CDB_WIDTH-1:0]        cdb_valid;
  logic [TAG_W*CDB_WIDTH-1:0]  cdb_tag;
  logic [XLEN*CDB_WIDTH-1:0]   cdb_value;
  logic [CDB_WIDTH-1:0]        cdb_mispred;

  logic [TAG_W*LK_PORTS-1:0]   lk_tag;
  logic [LK_PORTS-1:0]         lk_ready;
  logic [XLEN*LK_PORTS-1:0]    lk_value;

  logic [RT_WIDTH-1:0]         rt_valid;
  logic [TAG_W*RT_WIDTH-1:0]   rt_tag;
  logic [5*RT_WIDTH-1:0]       rt_dest;
  logic [RT_WIDTH-1:0]         rt_has_dest;
  logic [XLEN*RT_WIDTH-1:0]    rt_value;
  logic                        flush;
  logic                        rob_empty;

  modport slave (
    input  dp_valid, dp_has_dest, dp_dest, dp_is_branch,
    input  cdb_valid, cdb_tag, cdb_value, cdb_mispred,
    input  lk_tag,
    output dp_accept, dp_tag, free_slots,
    output lk_ready, lk_value,
    output rt_valid, rt_tag, rt_dest, rt_has_dest, rt_value,
    output flush, rob_empty
  );

  modport master (
    output dp_valid, dp_has_dest, dp_dest, dp_is_branch,
    output cdb_valid, cdb_tag, cdb_value, cdb_mispred,
    output lk_tag,
    input  dp_accept, dp_tag, free_slots,
    input  lk_ready, lk_value,
    input  rt_valid, rt_tag, rt_dest, rt_has_dest, rt_value,
    input  flush, rob_empty
  );
endinterface

// File: rtl/rob_multiway.sv
// Multi-issue reorder buffer: wide dispatch, CDB completion,
// in-order multi-lane retire, flush on mispredicted branch retire.
module rob_multiway #(
  parameter int ROB_DEPTH = 8,
  parameter int DP_WIDTH  = 2,
  parameter int CDB_WIDTH = 2,
  parameter int RT_WIDTH  = 2,
  parameter int LK_PORTS  = 4,
  parameter int XLEN      = 32
) (
  input logic           clock,
  input logic           reset,
  rob_multiway_if.slave rob
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = TAG_W + 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic            vld;
    logic            cmp;
    logic            mis;
    logic            br;
    logic            hd;
    logic [4:0]      dst;
    logic [XLEN-1:0] val;
  } ent_t;

  ent_t ent_q [ROB_DEPTH];
  ent_t ent_d [ROB_DEPTH];
  tag_t head_q, head_d;
  tag_t tail_q, tail_d;
  cnt_t cnt_q, cnt_d;

  cnt_t                free;
  cnt_t                n_dp;
  cnt_t                n_rt;
  logic                acc;
  logic                flush;
  logic [RT_WIDTH-1:0] rt_v;

  assign free = cnt_t'(ROB_DEPTH) - cnt_q;
  assign acc  = !flush && (n_dp <= free);

  assign rob.dp_accept  = acc;
  assign rob.free_slots = free;
  assign rob.flush      = flush;
  assign rob.rob_empty  = (cnt_q == '0);
  assign rob.rt_valid   = rt_v;

  always_comb begin
    n_dp       = '0;
    rob.dp_tag = '0;
    for (int i = 0; i < DP_WIDTH; i++) begin
      if (rob.dp_valid[i]) n_dp = n_dp + cnt_t'(1);
      rob.dp_tag[i*TAG_W +: TAG_W] = tail_q + tag_t'(i);
    end
  end

  // A mispredicted entry closes its retire group.
  always_comb begin
    logic go;
    tag_t idx;
    go              = 1'b1;
    flush           = 1'b0;
    n_rt            = '0;
    rt_v            = '0;
    rob.rt_tag      = '0;
    rob.rt_dest     = '0;
    rob.rt_has_dest = '0;
    rob.rt_value    = '0;
    for (int i = 0; i < RT_WIDTH; i++) begin
      idx = head_q + tag_t'(i);
      if (go && ent_q[idx].vld && ent_q[idx].cmp) begin
        rt_v[i] = 1'b1;
        n_rt    = n_rt + cnt_t'(1);
        if (ent_q[idx].mis) begin
          flush = 1'b1;
          go    = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
      rob.rt_tag[i*TAG_W +: TAG_W] = idx;
      rob.rt_dest[i*5 +: 5]        = ent_q[idx].dst;
      rob.rt_has_dest[i]           = ent_q[idx].hd;
      rob.rt_value[i*XLEN +: XLEN] = ent_q[idx].val;
    end
  end

  always_comb begin
    tag_t idx;
    ent_d  = ent_q;
    head_d = head_q + tag_t'(n_rt);
    tail_d = tail_q;
    cnt_d  = cnt_q + (acc ? n_dp : '0) - n_rt;
    for (int i = 0; i < RT_WIDTH; i++) begin
      idx = head_q + tag_t'(i);
      if (rt_v[i]) ent_d[idx] = '0;
    end
    for (int c = 0; c < CDB_WIDTH; c++) begin
      idx = rob.cdb_tag[c*TAG_W +: TAG_W];
      if (rob.cdb_valid[c] && ent_q[idx].vld && !ent_q[idx].cmp) begin
        ent_d[idx].cmp = 1'b1;
        ent_d[idx].mis = rob.cdb_mispred[c];
        ent_d[idx].val = rob.cdb_value[c*XLEN +: XLEN];
      end
    end
    if (acc) begin
      for (int i = 0; i < DP_WIDTH; i++) begin
        idx = tail_q + tag_t'(i);
        if (rob.dp_valid[i]) begin
          ent_d[idx].vld = 1'b1;
          ent_d[idx].cmp = 1'b0;
          ent_d[idx].mis = 1'b0;
          ent_d[idx].br  = rob.dp_is_branch[i];
          ent_d[idx].hd  = rob.dp_has_dest[i];
          ent_d[idx].dst = rob.dp_dest[i*5 +: 5];
          ent_d[idx].val = '0;
        end
      end
      tail_d = tail_q + tag_t'(n_dp);
    end
    if (flush) begin
      for (int k = 0; k < ROB_DEPTH; k++) ent_d[k] = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_comb begin
    tag_t idx;
    rob.lk_ready = '0;
    rob.lk_value = '0;
    for (int p = 0; p < LK_PORTS; p++) begin
      idx = rob.lk_tag[p*TAG_W +: TAG_W];
      if (ent_q[idx].vld && ent_q[idx].cmp) begin
        rob.lk_ready[p]              = 1'b1;
        rob.lk_value[p*XLEN +: XLEN] = ent_q[idx].val;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < ROB_DEPTH; k++) ent_q[k] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  localparam logic [DP_WIDTH-1:0] DP_ONE = 1;

  a_dp_contig: assert property (
    @(posedge clock) disable iff (reset)
    ((rob.dp_valid & (rob.dp_valid + DP_ONE)) == '0)
  );
endmodule

// File: doc/rob_multiway.md
# rob_multiway

Parametrised reorder buffer and successor to the single-issue ROB. Accepts up to `DP_WIDTH` in-order dispatches and `CDB_WIDTH` completions per cycle, and retires up to `RT_WIDTH` completed head entries per cycle. On retirement of a mispredicted branch it flushes all younger entries. Sits between dispatch, the CDB and the retire stage, and provides operand-forwarding lookups for dispatch.

## Interface

Parameters:
- `ROB_DEPTH`, 8: number of entries; power of 2, ≥ 4. `TAG_W = $clog2(ROB_DEPTH)`.
- `DP_WIDTH`, 2: dispatch lanes.
- `CDB_WIDTH`, 2: completion lanes.
- `RT_WIDTH`, 2: retire lanes; ≤ `ROB_DEPTH`.
- `LK_PORTS`, 4: operand lookup ports.
- `XLEN`, 32: data width.

Ports (per-lane signals are packed arrays, lane 0 in the LSBs):
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `dp_valid` in `DP_WIDTH`: dispatch requests; lanes must be contiguous from lane 0.
- `dp_has_dest` in `DP_WIDTH`: lane writes an architectural register.
- `dp_dest` in `5*DP_WIDTH`: destination register index.
- `dp_is_branch` in `DP_WIDTH`: lane is a branch.
- `dp_accept` out 1: all requested lanes accepted this cycle.
- `dp_tag` out `TAG_W*DP_WIDTH`: tag allocated per lane (tail+i).
- `free_slots` out `TAG_W+1`: `ROB_DEPTH - count`; registered.
- `cdb_valid` in `CDB_WIDTH`: completion valid.
- `cdb_tag` in `TAG_W*CDB_WIDTH`: completing tag.
- `cdb_value` in `XLEN*CDB_WIDTH`: result.
- `cdb_mispred` in `CDB_WIDTH`: branch resolved mispredicted.
- `lk_tag` in `TAG_W*LK_PORTS`: lookup tag.
- `lk_ready` out `LK_PORTS`: entry valid and complete.
- `lk_value` out `XLEN*LK_PORTS`: entry value; 0 when not ready.
- `rt_valid` out `RT_WIDTH`: retiring this cycle; contiguous from lane 0.
- `rt_tag`, `rt_dest`, `rt_has_dest`, `rt_value` out (per lane): retiring entry fields.
- `flush` out 1: mispredicted branch retiring this cycle; younger state is discarded.
- `rob_empty` out 1: count == 0.

## Operation

- State: entry array (valid, complete, mispred, is_branch, has_dest, dest, value), `head`, `tail` (`TAG_W`, natural wrap), `count` (`TAG_W+1`).
- Dispatch:
  - `dp_accept = !flush && popcount(dp_valid) <= free_slots`. All-or-nothing.
  - On accept, lane i writes entry `tail+i` (mod `ROB_DEPTH`) with complete=0; `tail += popcount`.
  - Non-contiguous `dp_valid` is illegal; behaviour undefined (assertion).
- Completion:
  - Each valid CDB lane whose tag hits a valid, incomplete entry sets complete=1, value, mispred.
  - Hits on invalid or already-complete entries are ignored.
  - Two lanes with the same tag in one cycle is illegal.
- Retire (combinational from current state):
  - Lane i retires iff entries `head..head+i` are all valid and complete, and no entry `head..head+i-1` has mispred=1.
  - A mispredicted entry retires as the last lane of its group. Retired entries are cleared; `head += retired`.
- Flush:
  - `flush=1` iff a retiring lane carries mispred=1.
  - At that edge: all entries are invalidated, `head=tail=0`, `count=0`. Same-cycle dispatch is rejected (`dp_accept=0`) and same-cycle completions are dropped.
- Count: `count_next = count + accepted - retired`. Never exceeds `ROB_DEPTH`.
- Lookup: purely combinational on current entry state. CDB writes in the same cycle are not forwarded.

## Timing

- Reset values: all entries invalid, `head=tail=count=0`, `free_slots=ROB_DEPTH`, `rob_empty=1`. Consequently `rt_valid=0`, `flush=0`, `lk_ready=0`, `lk_value=0`, `dp_tag` lane i = i, and `dp_accept = (popcount(dp_valid) ≤ ROB_DEPTH)`.
- Reset has priority over every other event, including mid-flush and mid-retire.
- Dispatch at edge N:
  - The entry is visible to lookup at N+1.
  - The earliest completion is at edge N+1, giving retire at N+1 combinationally and head advance at edge N+2.
- Latency from CDB to retire: 1 cycle when the entry is at head.
- `free_slots` does not credit same-cycle retires. A full ROB accepts again in the cycle after a retire.
- Simultaneous retire and dispatch is allowed. Retire frees slots from the head and dispatch consumes slots at the tail; there is no overlap because the accept check uses the registered count.
- Wrap-around: `head`/`tail` roll from `ROB_DEPTH-1` to 0. Full is distinguished from empty by `count`.

## Test plan

1. Reset, then dispatch 2/cycle for 4 cycles (8 ops) → tags 0–7, `free_slots` 8→0; 5th request shows `dp_accept=0`; `rob_empty=0`.
2. Complete tags 1, 0 in consecutive cycles → no retire after tag 1; after tag 0, `rt_valid=2'b11` with tags 0,1 and matching values; `free_slots=2` next cycle.
3. Complete tags 2, 3, 4 with 3 and 4 out of order → retire ≤2/cycle in order: 2,3 then 4; `dp_tag` wraps to 0 after tag 7.
4. Branch at tag 2 completes mispred=1 while tags 3–5 are complete → retire 2 alone with `flush=1`; next cycle `count=0`, `head=tail=0`, a same-cycle dispatch is rejected, and tag 3 never appears on `rt_valid`.
5. Lookup tag 5 before/after CDB value 0xDEADBEEF → `lk_ready=0`, `lk_value=0`, then the next cycle `lk_ready=1`, `lk_value=0xDEADBEEF`; CDB on an invalid tag leaves the state unchanged.
6. Assert `reset` while the ROB is full and a flush is pending → next cycle all reset values, `flush=0`.
